// File: rtl/imem_loader_if.sv
// Byte-stream input and word-write output of the boot loader.
// master: the loader side; slave: byte source plus memory array side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: parses LEN_LO, LEN_HI, N*4 payload bytes, CSUM
// from a byte stream and writes little-endian 32-bit words to instruction
// memory, holding the CPU in reset while the load is in progress.
module imem_loader #(
  parameter int unsigned WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  // Word index must be able to represent WORDS itself (end-of-frame compare).
  localparam int unsigned IDX_W = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [15:0]      len_q, len_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [31:0]      buf_q, buf_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             byte_ready;
  logic             xfer;
  logic [15:0]      len_full;
  logic [IDX_W-1:0] word_next;
  logic             start_ok;

  // Ready depends on state only, so the source sees it without a loop.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      LEN0, LEN1, DATA, CSUM: byte_ready = 1'b1;
      default:                byte_ready = 1'b0;
    endcase
  end

  assign xfer      = bus.byte_valid && byte_ready;
  assign len_full  = {bus.byte_data, len_lo_q};
  assign word_next = word_idx_q + 1'b1;
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          state_d    = LEN0;
          word_idx_d = '0;
          byte_idx_d = '0;
          sum_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      LEN0: begin
        if (xfer) begin
          len_lo_d = bus.byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > WORDS) begin
            state_d = ERR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          buf_d[8*byte_idx_q +: 8] = bus.byte_data;
          sum_d      = sum_q + bus.byte_data;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            // Write port is loaded on entry to WRITE so it stays stable elsewhere.
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'(word_idx_q) << 2;
            mem_wdata_d = buf_d;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_next;
        byte_idx_d = '0;
        if (32'(word_next) == 32'(len_q)) state_d = CSUM;
        else                              state_d = DATA;
      end
      CSUM: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (bus.byte_data == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      sum_q       <= '0;
      buf_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      sum_q       <= sum_d;
      buf_q       <= buf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;
  assign cpu_hold       = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  logic clk;
  logic rst;
  logic start;
  logic busy, cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.WORDS(4096)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until the loader takes it (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.byte_ready === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    check("byte_accept_timeout", {31'b0, bus.byte_ready}, 32'd1);
  endtask

  task automatic send_byte_bp(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 3);
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'hXX;
      tick();
    end
    send_byte(b);
  endtask

  task automatic idle();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic pulse_start();
    idle();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic e);
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
    check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, b});
    check({tag, "_done"}, {31'b0, done}, {31'b0, d});
    check({tag, "_error"}, {31'b0, error}, {31'b0, e});
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      check({tag, "_addr"}, wr_addr[idx], a);
      check({tag, "_data"}, wr_data[idx], d);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    idle();
    tick();
    tick();

    // Reset values
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("rst_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'b0, bus.byte_ready}, 32'd0);

    // Two-word load
    clear_writes();
    pulse_start();
    check_flags("start1", 1'b1, 1'b0, 1'b0);
    check("start1_ready", {31'b0, bus.byte_ready}, 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("w0_we", {31'b0, bus.mem_we}, 32'd1);
    check("w0_addr_live", bus.mem_addr, 32'h0);
    check("w0_data_live", bus.mem_wdata, 32'h00000013);
    check("w0_ready_low", {31'b0, bus.byte_ready}, 32'd0);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h82);
    idle();
    check_flags("load2", 1'b0, 1'b1, 1'b0);
    check("load2_nwr", 32'(wr_addr.size()), 32'd2);
    check_write("load2_w0", 0, 32'h0, 32'h00000013);
    check_write("load2_w1", 1, 32'h4, 32'h0000006F);
    tick();
    check("done_we_low", {31'b0, bus.mem_we}, 32'd0);
    check("done_addr_hold", bus.mem_addr, 32'h4);
    check("done_ready_low", {31'b0, bus.byte_ready}, 32'd0);

    // Bad checksum
    clear_writes();
    pulse_start();
    check_flags("start2", 1'b1, 1'b0, 1'b0);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h83);
    idle();
    check_flags("badsum", 1'b0, 1'b0, 1'b1);
    check("badsum_nwr", 32'(wr_addr.size()), 32'd2);
    check_write("badsum_w1", 1, 32'h4, 32'h0000006F);

    // Oversize length 0x1001
    clear_writes();
    pulse_start();
    check_flags("start3", 1'b1, 1'b0, 1'b0);
    send_byte(8'h01); send_byte(8'h10);
    check_flags("oversize", 1'b0, 1'b0, 1'b1);
    check("oversize_ready", {31'b0, bus.byte_ready}, 32'd0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    tick(); tick(); tick();
    idle();
    check("oversize_ready_later", {31'b0, bus.byte_ready}, 32'd0);
    check("oversize_nwr", 32'(wr_addr.size()), 32'd0);
    check("oversize_error_sticky", {31'b0, error}, 32'd1);

    // Boundary length 4096 is accepted (abandoned mid-frame by reset below)
    pulse_start();
    send_byte(8'h00); send_byte(8'h10);
    check("len4096_ready", {31'b0, bus.byte_ready}, 32'd1);
    check("len4096_error", {31'b0, error}, 32'd0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Zero length
    clear_writes();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle();
    check_flags("zero", 1'b0, 1'b1, 1'b0);
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // One word with random back-pressure: EF+BE+AD+DE = 0x338 -> 0x38
    clear_writes();
    pulse_start();
    send_byte_bp(8'h01); send_byte_bp(8'h00);
    send_byte_bp(8'hEF); send_byte_bp(8'hBE); send_byte_bp(8'hAD); send_byte_bp(8'hDE);
    send_byte_bp(8'h38);
    idle();
    check_flags("bp", 1'b0, 1'b1, 1'b0);
    check("bp_nwr", 32'(wr_addr.size()), 32'd1);
    check_write("bp_w0", 0, 32'h0, 32'hDEADBEEF);

    // Reset mid-frame after 3 payload bytes of word 1
    clear_writes();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle();
    rst = 1'b1;
    tick();
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    check("midrst_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("midrst_we", {31'b0, bus.mem_we}, 32'd0);
    check("midrst_addr", bus.mem_addr, 32'h0);
    check("midrst_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    tick();
    check("midrst_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'hAA);
    idle();
    check_flags("afterrst", 1'b0, 1'b1, 1'b0);
    check_write("afterrst_w0", 0, 32'h0, 32'h11223344);

    // Start while busy is ignored
    clear_writes();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle();
    tick();
    pulse_start();
    check("busystart_busy", {31'b0, busy}, 32'd1);
    check("busystart_ready", {31'b0, bus.byte_ready}, 32'd1);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h82);
    idle();
    check_flags("busystart_end", 1'b0, 1'b1, 1'b0);
    check("busystart_nwr", 32'(wr_addr.size()), 32'd2);
    check_write("busystart_w0", 0, 32'h0, 32'h00000013);
    check_write("busystart_w1", 1, 32'h4, 32'h0000006F);

    // Start from DONE clears done and begins a new load
    clear_writes();
    pulse_start();
    check_flags("restart", 1'b1, 1'b0, 1'b0);
    check("restart_ready", {31'b0, bus.byte_ready}, 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle();
    check_flags("restart_end", 1'b0, 1'b1, 1'b0);
    check("restart_nwr", 32'(wr_addr.size()), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
